// File: rtl/syntzulu_pkg.sv
// -----------------------------------------------------------------------------
// syntzulu_pkg
// Shared definitions for the readout path of the network core.
//   clogb2       : bits needed to hold the argument value (minimum 1)
//   obuf_state_t : output buffer phase, FILL (collect) or DRAIN (transmit)
//   SIMD_DW      : result width that triggers two-values-per-word packing
// -----------------------------------------------------------------------------
package syntzulu_pkg;

  localparam int SIMD_DW = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } obuf_state_t;

  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/output_buffer_if.sv
// -----------------------------------------------------------------------------
// output_buffer_if
// Streaming signals of the output buffer: core result input and the
// valid/ready word stream towards the host transmitter.
//   in_valid / in_data   : core -> buffer, one value per asserted cycle
//   tx_valid / tx_data   : buffer -> transmitter, 16-bit words
//   tx_ready             : transmitter -> buffer, word accepted
// Modports: master = core/transmitter side, slave = the buffer itself.
// -----------------------------------------------------------------------------
interface output_buffer_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          tx_valid;
  logic [15:0]   tx_data;
  logic          tx_ready;

  modport master (
    output in_valid, in_data, tx_ready,
    input  tx_valid, tx_data
  );

  modport slave (
    input  in_valid, in_data, tx_ready,
    output tx_valid, tx_data
  );
endinterface

// File: rtl/BRAM_singlePort_readFirst.sv
// -----------------------------------------------------------------------------
// BRAM_singlePort_readFirst
// Single-port block RAM, read-first: a write cycle returns the old contents.
//   clk  : clock
//   we   : write enable
//   addr : shared read/write address
//   din  : write data
//   dout : read data, 1 cycle after addr (LOW_LATENCY=1) or 2 cycles (=0)
// -----------------------------------------------------------------------------
module BRAM_singlePort_readFirst #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int LOW_LATENCY = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // NOTE: the array has no reset branch on purpose; resetting a memory forces
  // it out of block RAM into flops, and no consumer reads a word unwritten.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    rd_q <= mem[addr];
  end

  if (LOW_LATENCY != 0) begin : g_low_lat
    assign dout = rd_q;
  end else begin : g_out_reg
    logic [DATA_W-1:0] out_q;
    always_ff @(posedge clk) out_q <= rd_q;
    assign dout = out_q;
  end
endmodule

// File: rtl/obuf_argmax.sv
// -----------------------------------------------------------------------------
// obuf_argmax
// Running signed maximum and its value index over one frame of results.
// Strictly-greater update, so ties keep the lowest index.
//   clk, rst     : clock, synchronous active-high reset
//   valid, data  : one accepted FILL value per asserted cycle
//   argmax_idx   : index of the frame maximum, held until the next frame ends
//   argmax_valid : one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module obuf_argmax
  import syntzulu_pkg::*;
#(
  parameter int OUTPUTS = 16,
  parameter int DW      = 16,
  localparam int IW     = clogb2(OUTPUTS-1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic signed [DW-1:0] data,
  output logic        [IW-1:0] argmax_idx,
  output logic                 argmax_valid
);
  logic        [IW-1:0] idx;
  logic        [IW-1:0] max_idx;
  logic signed [DW-1:0] max_val;
  logic                 take_new;
  logic                 last;

  // The first value of a frame always loads, whatever max_val holds.
  assign take_new = (idx == '0) || (data > max_val);
  assign last     = (idx == IW'(OUTPUTS-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      max_idx      <= '0;
      max_val      <= '0;
      argmax_idx   <= '0;
      argmax_valid <= 1'b0;
    end else begin
      argmax_valid <= 1'b0;
      if (valid) begin
        if (take_new) begin
          max_val <= data;
          max_idx <= idx;
        end
        if (last) begin
          idx          <= '0;
          argmax_idx   <= take_new ? idx : max_idx;
          argmax_valid <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/output_buffer.sv
// -----------------------------------------------------------------------------
// output_buffer
// Collects one frame of OUTPUTS signed core results, then drains it as 16-bit
// words over a valid/ready handshake. With DW==8 two values share a word,
// low byte first. A host read port gives random access to the frame memory.
//   clk, rst           : clock, synchronous active-high reset
//   bus (slave)        : in_valid/in_data in, tx_valid/tx_data/tx_ready out
//   frame_done         : pulse after the last word of a frame is accepted
//   overflow           : sticky, a value arrived while draining
//   clear_ovf          : clears overflow (a simultaneous new overflow wins)
//   external_access_en : host read; pauses the drain while asserted
//   external_addr      : host word address
//   external_data_out  : memory word, 1 cycle after external_addr
// Optional (macro OUTPUT_BUFFER_ARGMAX_EN): argmax_idx, argmax_valid.
// -----------------------------------------------------------------------------
module output_buffer
  import syntzulu_pkg::*;
#(
  parameter int  OUTPUTS = 16,
  parameter int  DW      = 16,
  localparam int WORDS   = (DW == SIMD_DW) ? OUTPUTS / 2 : OUTPUTS,
  localparam int AW      = clogb2(WORDS-1)
) (
  input  logic                  clk,
  input  logic                  rst,
  output_buffer_if.slave        bus,
  output logic                  frame_done,
  output logic                  overflow,
  input  logic                  clear_ovf,
  input  logic                  external_access_en,
  input  logic [AW-1:0]         external_addr,
  output logic [15:0]           external_data_out
`ifdef OUTPUT_BUFFER_ARGMAX_EN
  ,
  output logic [clogb2(OUTPUTS-1)-1:0] argmax_idx,
  output logic                         argmax_valid
`endif
);
  localparam bit            SIMD      = (DW == SIMD_DW);
  localparam logic [AW-1:0] LAST_WORD = AW'(WORDS-1);

  obuf_state_t   state, state_next;
  logic [AW-1:0] wr_ptr, wr_ptr_next;
  logic [AW-1:0] rd_ptr, rd_ptr_next;
  logic [AW-1:0] drain_addr, mem_addr;
  logic          tx_valid_q, tx_valid_next;
  logic          frame_done_next;
  logic          fill_push, word_complete, mem_we, accept;
  logic [15:0]   mem_wdata, mem_rdata;

  assign fill_push = (state == FILL) && bus.in_valid;
  assign mem_we    = fill_push && word_complete;

  // A host read masks the handshake combinationally, so a word can never be
  // accepted in the same cycle that the read port steals the address.
  assign bus.tx_valid = tx_valid_q && !external_access_en;
  assign bus.tx_data  = bus.tx_valid ? mem_rdata : 16'h0000;
  assign accept       = bus.tx_valid && bus.tx_ready;

  // Prefetch the next word on acceptance to sustain one word per cycle.
  assign drain_addr = accept ? rd_ptr + 1'b1 : rd_ptr;
  assign mem_addr   = mem_we             ? wr_ptr        :
                      external_access_en ? external_addr : drain_addr;

  assign external_data_out = mem_rdata;

  if (SIMD) begin : g_simd
    logic       half;
    logic [7:0] low_byte;

    always_ff @(posedge clk) begin
      if (rst)            half <= 1'b0;
      else if (fill_push) half <= ~half;
    end

    always_ff @(posedge clk) begin
      if (fill_push && !half) low_byte <= bus.in_data[7:0];
    end

    assign word_complete = half;
    assign mem_wdata     = {bus.in_data[7:0], low_byte};
  end else begin : g_wide
    assign word_complete = 1'b1;
    assign mem_wdata     = 16'($signed(bus.in_data));
  end

  BRAM_singlePort_readFirst #(
    .DATA_W      (16),
    .DEPTH       (WORDS),
    .ADDR_W      (AW),
    .LOW_LATENCY (1)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (mem_wdata),
    .dout (mem_rdata)
  );

  // NOTE: every output of this block gets its default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    wr_ptr_next     = wr_ptr;
    rd_ptr_next     = rd_ptr;
    tx_valid_next   = tx_valid_q;
    frame_done_next = 1'b0;
    case (state)
      FILL: begin
        if (mem_we) begin
          if (wr_ptr == LAST_WORD) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            state_next  = DRAIN;
          end else begin
            wr_ptr_next = wr_ptr + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (external_access_en) begin
          // Dropping valid forces a reload read of mem[rd_ptr] after release.
          tx_valid_next = 1'b0;
        end else if (accept) begin
          if (rd_ptr == LAST_WORD) begin
            tx_valid_next   = 1'b0;
            frame_done_next = 1'b1;
            rd_ptr_next     = '0;
            state_next      = FILL;
          end else begin
            rd_ptr_next   = rd_ptr + 1'b1;
            tx_valid_next = 1'b1;
          end
        end else begin
          // Either the first read of the drain or a stall on the same word.
          tx_valid_next = 1'b1;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tx_valid_q <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      tx_valid_q <= tx_valid_next;
      frame_done <= frame_done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  overflow <= 1'b0;
    else if (state == DRAIN && bus.in_valid)  overflow <= 1'b1;
    else if (clear_ovf)                       overflow <= 1'b0;
  end

`ifdef OUTPUT_BUFFER_ARGMAX_EN
  obuf_argmax #(
    .OUTPUTS (OUTPUTS),
    .DW      (DW)
  ) u_argmax (
    .clk          (clk),
    .rst          (rst),
    .valid        (fill_push),
    .data         (bus.in_data),
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
  );
`endif
endmodule

// File: tb/tb_output_buffer.sv
// -----------------------------------------------------------------------------
// tb_output_buffer
// Directed bench for output_buffer: a DW=16 instance for fill/drain,
// backpressure, overflow, host read and reset, and a DW=8 instance for SIMD
// packing. Argmax checks are compiled in with OUTPUT_BUFFER_ARGMAX_EN.
// -----------------------------------------------------------------------------
module tb_output_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_buffer_if #(.DW(16)) b16 ();
  output_buffer_if #(.DW(8))  b8 ();

  logic        fd16, ovf16, clr16, ext_en16;
  logic [1:0]  ext_addr16;
  logic [15:0] ext_do16;
  logic        fd8, ovf8, clr8, ext_en8;
  logic [0:0]  ext_addr8;
  logic [15:0] ext_do8;
`ifdef OUTPUT_BUFFER_ARGMAX_EN
  logic [1:0]  amx_idx16, amx_idx8;
  logic        amx_v16, amx_v8;
`endif

  output_buffer #(.OUTPUTS(4), .DW(16)) dut16 (
    .clk                (clk),
    .rst                (rst),
    .bus                (b16),
    .frame_done         (fd16),
    .overflow           (ovf16),
    .clear_ovf          (clr16),
    .external_access_en (ext_en16),
    .external_addr      (ext_addr16),
    .external_data_out  (ext_do16)
`ifdef OUTPUT_BUFFER_ARGMAX_EN
    ,
    .argmax_idx         (amx_idx16),
    .argmax_valid       (amx_v16)
`endif
  );

  output_buffer #(.OUTPUTS(4), .DW(8)) dut8 (
    .clk                (clk),
    .rst                (rst),
    .bus                (b8),
    .frame_done         (fd8),
    .overflow           (ovf8),
    .clear_ovf          (clr8),
    .external_access_en (ext_en8),
    .external_addr      (ext_addr8),
    .external_data_out  (ext_do8)
`ifdef OUTPUT_BUFFER_ARGMAX_EN
    ,
    .argmax_idx         (amx_idx8),
    .argmax_valid       (amx_v8)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_w [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns 1 time unit after the rising edge: outputs settled, inputs safe.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill16(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    logic [15:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      b16.in_valid = 1'b1;
      b16.in_data  = v[i];
      tick();
    end
    b16.in_valid = 1'b0;
    b16.in_data  = '0;
  endtask

  // Drains one frame of the DW=16 instance with tx_ready following pat
  // (bit c%4 in cycle c); every presented word must be the next expected one.
  task automatic drain16(input logic [3:0] pat, input string tag);
    int n_acc;
    int n_done;
    n_acc  = 0;
    n_done = 0;
    for (int c = 0; c < 40 && n_done == 0; c++) begin
      b16.tx_ready = pat[c % 4];
      if (b16.tx_valid) begin
        if (n_acc < 4) check({tag, "_word"}, 32'(b16.tx_data), 32'(exp_w[n_acc]));
        if (b16.tx_ready) n_acc++;
      end
      tick();
      if (fd16) n_done++;
    end
    b16.tx_ready = 1'b0;
    check({tag, "_count"}, n_acc, 4);
    check({tag, "_done"}, n_done, 1);
  endtask

  initial begin
    b16.in_valid = 1'b0; b16.in_data = '0; b16.tx_ready = 1'b0;
    b8.in_valid  = 1'b0; b8.in_data  = '0; b8.tx_ready  = 1'b0;
    clr16 = 1'b0; ext_en16 = 1'b0; ext_addr16 = '0;
    clr8  = 1'b0; ext_en8  = 1'b0; ext_addr8  = '0;

    // Reset values
    rst = 1'b1;
    repeat (2) tick();
    check("rst_txv16", b16.tx_valid, 0);
    check("rst_txd16", b16.tx_data, 0);
    check("rst_fd16",  fd16, 0);
    check("rst_ovf16", ovf16, 0);
    check("rst_txv8",  b8.tx_valid, 0);
    check("rst_txd8",  b8.tx_data, 0);
    check("rst_fd8",   fd8, 0);
    check("rst_ovf8",  ovf8, 0);
    rst = 1'b0;

    // Non-SIMD fill/drain with sign extension and exact latency
    b16.tx_ready = 1'b1;
    exp_w = '{16'h0001, 16'hFFFE, 16'h0003, 16'h7FFF};
    fill16(16'h0001, 16'hFFFE, 16'h0003, 16'h7FFF);
    check("t1_lat_not_yet", b16.tx_valid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", b16.tx_valid, 1);
      check("t1_data", 32'(b16.tx_data), 32'(exp_w[i]));
      tick();
    end
    check("t1_valid_drop", b16.tx_valid, 0);
    check("t1_frame_done", fd16, 1);
    tick();
    check("t1_frame_done_pulse", fd16, 0);
    b16.tx_ready = 1'b0;

    // SIMD packing, low byte first
    b8.tx_ready = 1'b1;
    b8.in_valid = 1'b1; b8.in_data = 8'h11; tick();
    b8.in_data = 8'h22; tick();
    b8.in_data = 8'h33; tick();
    b8.in_data = 8'h44; tick();
    b8.in_valid = 1'b0; b8.in_data = '0;
    check("simd_lat", b8.tx_valid, 0);
    tick();
    check("simd_v0", b8.tx_valid, 1);
    check("simd_w0", b8.tx_data, 16'h2211);
    tick();
    check("simd_v1", b8.tx_valid, 1);
    check("simd_w1", b8.tx_data, 16'h4433);
    tick();
    check("simd_drop", b8.tx_valid, 0);
    check("simd_done", fd8, 1);
    b8.tx_ready = 1'b0;
    ext_en8 = 1'b1; ext_addr8 = 1'b1;
    tick();
    check("simd_ext_w1", ext_do8, 16'h4433);
    ext_en8 = 1'b0;

    // Backpressure 1,0,0,1
    exp_w = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    fill16(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    drain16(4'b1001, "bp");

    // Overflow: first push with clear_ovf (set wins), second push alone
    exp_w = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    fill16(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    b16.in_valid = 1'b1; b16.in_data = 16'hDEAD; clr16 = 1'b1;
    tick();
    clr16 = 1'b0;
    check("ovf_set_wins", ovf16, 1);
    b16.in_data = 16'hBEEF;
    tick();
    b16.in_valid = 1'b0; b16.in_data = '0;
    check("ovf_set", ovf16, 1);
    drain16(4'b1111, "ovf_drain");
    exp_w = '{16'h0005, 16'h0006, 16'h0007, 16'h0008};
    fill16(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    drain16(4'b1111, "ovf_next");
    check("ovf_sticky", ovf16, 1);
    clr16 = 1'b1;
    tick();
    clr16 = 1'b0;
    check("ovf_clear", ovf16, 0);

    // Host read mid-drain, then resume at the held word after one bubble
    b16.tx_ready = 1'b1;
    fill16(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    tick();
    check("ext_pre_w0", b16.tx_data, 16'h1111);
    tick();
    check("ext_pre_w1", b16.tx_data, 16'h2222);
    ext_en16 = 1'b1; ext_addr16 = 2'd2;
    #1;
    check("ext_gate", b16.tx_valid, 0);
    tick();
    check("ext_data", ext_do16, 16'h3333);
    ext_en16 = 1'b0;
    #1;
    check("ext_reload", b16.tx_valid, 0);
    tick();
    check("ext_resume_v", b16.tx_valid, 1);
    check("ext_resume_w1", b16.tx_data, 16'h2222);
    tick();
    check("ext_w2", b16.tx_data, 16'h3333);
    tick();
    check("ext_w3", b16.tx_data, 16'h4444);
    tick();
    check("ext_done", fd16, 1);
    b16.tx_ready = 1'b0;

    // Reset mid-drain with overflow set
    fill16(16'h0006, 16'h0007, 16'h0008, 16'h0009);
    tick();
    tick();
    b16.in_valid = 1'b1; b16.in_data = 16'h0055;
    tick();
    b16.in_valid = 1'b0; b16.in_data = '0;
    check("mid_valid", b16.tx_valid, 1);
    check("mid_ovf", ovf16, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_txv", b16.tx_valid, 0);
    check("rst2_txd", b16.tx_data, 0);
    check("rst2_fd", fd16, 0);
    check("rst2_ovf", ovf16, 0);
`ifdef OUTPUT_BUFFER_ARGMAX_EN
    check("rst2_amx_idx", amx_idx16, 0);
    check("rst2_amx_v", amx_v16, 0);
    check("rst2_amx_idx8", amx_idx8, 0);
    check("rst2_amx_v8", amx_v8, 0);
`endif

    // Fresh frame after reset, argmax with a tie
    b16.tx_ready = 1'b1;
    exp_w = '{16'h0005, 16'h0009, 16'h0009, 16'hFFFF};
    fill16(16'h0005, 16'h0009, 16'h0009, 16'hFFFF);
`ifdef OUTPUT_BUFFER_ARGMAX_EN
    check("amx_valid", amx_v16, 1);
    check("amx_idx", amx_idx16, 1);
`endif
    tick();
`ifdef OUTPUT_BUFFER_ARGMAX_EN
    check("amx_valid_pulse", amx_v16, 0);
    check("amx_idx_hold", amx_idx16, 1);
`endif
    drain16(4'b1111, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
